// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-predictor update scheduler.
//   bp_upd_t        : one resolved branch (pc + actual direction)
//   bp_idx()        : local-history table index, pc[idx_w+1:2]
//   BP_DEPTH_DEFAULT: default queue depth
package bp_pkg;

    localparam int BP_DEPTH_DEFAULT = 8;
    localparam int BP_IDX_W_DEFAULT = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic        taken;
    } bp_upd_t;

    // Word-aligned index into the local table; upper bits masked to zero.
    function automatic logic [63:0] bp_idx(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Two-write / two-read circular buffer holding resolved branches in program order.
// Ports:
//   clock, reset_n          : clock, synchronous active-low reset
//   flush                   : clear pointers and count at the next edge
//   wr_en1/wr_data1         : older write, lands at the tail
//   wr_en2/wr_data2         : younger write, lands after wr_data1 (or at the tail alone)
//   rd_pop                  : number of entries popped this edge (0..2)
//   rd_data1/rd_data2       : head and head+1 entries
//   count                   : occupied entries
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             wr_en1,
    input  bp_upd_t          wr_data1,
    input  logic             wr_en2,
    input  bp_upd_t          wr_data2,
    input  logic [1:0]       rd_pop,
    output bp_upd_t          rd_data1,
    output bp_upd_t          rd_data2,
    output logic [CNT_W-1:0] count
);

    bp_upd_t          mem_q [DEPTH];
    bp_upd_t          mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       n_wr;

    always_comb begin
        mem_d = mem_q;
        n_wr  = 2'd0;
        if (wr_en1) begin
            mem_d[wr_ptr_q] = wr_data1;
            n_wr = 2'd1;
        end
        // Slot 2 follows slot 1 when both write, otherwise takes the tail itself.
        if (wr_en2) begin
            mem_d[wr_ptr_q + PTR_W'(n_wr)] = wr_data2;
            n_wr = n_wr + 2'd1;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_pop);
        count_d  = count_q + CNT_W'(n_wr) - CNT_W'(rd_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign rd_data1 = mem_q[rd_ptr_q];
    assign rd_data2 = mem_q[rd_ptr_q + PTR_W'(1)];
    assign count    = count_q;

endmodule

// File: rtl/bp_update_sched.sv
// Scheduler between complete/retire and the local-history predictor update ports.
// Buffers up to two resolved branches per cycle in program order and issues up to
// two per cycle on registered update ports.
// Optional feature macro: BP_SAME_INDEX_SERIALIZE_EN -- when defined, head and
// head+1 sharing a local-table index are issued on consecutive cycles instead of
// together.
// Ports:
//   clock, reset_n                   : clock, synchronous active-low reset
//   pred_enable                      : predictor enabled; low flushes the queue
//   upd_hold                         : suppress issue this cycle
//   cmp_valid/pc/taken 1,2           : resolved branches, slot 1 older
//   cmp_ready                        : at least two free entries
//   upd_valid/pc/result 1,2          : registered predictor update ports
//   queue_count                      : occupied entries
//   overflow_err                     : sticky, a valid input was dropped
module bp_update_sched
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH_DEFAULT,
    parameter int IDX_W = BP_IDX_W_DEFAULT,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pred_enable,
    input  logic             upd_hold,
    input  logic             cmp_valid1,
    input  logic [63:0]      cmp_pc1,
    input  logic             cmp_taken1,
    input  logic             cmp_valid2,
    input  logic [63:0]      cmp_pc2,
    input  logic             cmp_taken2,
    output logic             cmp_ready,
    output logic             upd_valid1,
    output logic [63:0]      upd_pc1,
    output logic             upd_result1,
    output logic             upd_valid2,
    output logic [63:0]      upd_pc2,
    output logic             upd_result2,
    output logic [CNT_W-1:0] queue_count,
    output logic             overflow_err
);

    bp_upd_t          head, head_nxt;
    bp_upd_t          wr_data1, wr_data2;
    logic [CNT_W-1:0] count;
    logic             wr_en1, wr_en2;
    logic             issue1, issue2, pair_ok;
    logic [1:0]       rd_pop;

    logic        upd_valid1_q, upd_valid1_d;
    logic [63:0] upd_pc1_q, upd_pc1_d;
    logic        upd_result1_q, upd_result1_d;
    logic        upd_valid2_q, upd_valid2_d;
    logic [63:0] upd_pc2_q, upd_pc2_d;
    logic        upd_result2_q, upd_result2_d;
    logic        overflow_q, overflow_d;

    bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (~pred_enable),
        .wr_en1   (wr_en1),
        .wr_data1 (wr_data1),
        .wr_en2   (wr_en2),
        .wr_data2 (wr_data2),
        .rd_pop   (rd_pop),
        .rd_data1 (head),
        .rd_data2 (head_nxt),
        .count    (count)
    );

    always_comb begin
        // Ready is taken from registered count only, ignoring same-cycle pops.
        cmp_ready = (count <= CNT_W'(DEPTH - 2));
        wr_en1    = pred_enable & cmp_ready & cmp_valid1;
        wr_en2    = pred_enable & cmp_ready & cmp_valid2;
        wr_data1  = '{pc: cmp_pc1, taken: cmp_taken1};
        wr_data2  = '{pc: cmp_pc2, taken: cmp_taken2};

        issue1 = pred_enable & ~upd_hold & (count != '0);
`ifdef BP_SAME_INDEX_SERIALIZE_EN
        pair_ok = (count >= CNT_W'(2)) &&
                  (bp_idx(head.pc, IDX_W) != bp_idx(head_nxt.pc, IDX_W));
`else
        pair_ok = (count >= CNT_W'(2));
`endif
        issue2 = issue1 & pair_ok;
        rd_pop = {1'b0, issue1} + {1'b0, issue2};

        upd_valid1_d  = issue1;
        upd_pc1_d     = issue1 ? head.pc : 64'd0;
        upd_result1_d = issue1 & head.taken;
        upd_valid2_d  = issue2;
        upd_pc2_d     = issue2 ? head_nxt.pc : 64'd0;
        upd_result2_d = issue2 & head_nxt.taken;

        overflow_d = overflow_q |
                     (pred_enable & ~cmp_ready & (cmp_valid1 | cmp_valid2));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            upd_valid1_q  <= 1'b0;
            upd_pc1_q     <= 64'd0;
            upd_result1_q <= 1'b0;
            upd_valid2_q  <= 1'b0;
            upd_pc2_q     <= 64'd0;
            upd_result2_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            upd_valid1_q  <= upd_valid1_d;
            upd_pc1_q     <= upd_pc1_d;
            upd_result1_q <= upd_result1_d;
            upd_valid2_q  <= upd_valid2_d;
            upd_pc2_q     <= upd_pc2_d;
            upd_result2_q <= upd_result2_d;
            overflow_q    <= overflow_d;
        end
    end

    assign upd_valid1   = upd_valid1_q;
    assign upd_pc1      = upd_pc1_q;
    assign upd_result1  = upd_result1_q;
    assign upd_valid2   = upd_valid2_q;
    assign upd_pc2      = upd_pc2_q;
    assign upd_result2  = upd_result2_q;
    assign queue_count  = count;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_bp_update_sched.sv
module tb_bp_update_sched;
    import bp_pkg::*;

    localparam int DEPTH = 8;
    localparam int IDX_W = 4;

    logic        clock = 1'b0;
    logic        reset_n, pred_enable, upd_hold;
    logic        cmp_valid1, cmp_taken1, cmp_valid2, cmp_taken2;
    logic [63:0] cmp_pc1, cmp_pc2;
    logic        cmp_ready, upd_valid1, upd_result1, upd_valid2, upd_result2;
    logic [63:0] upd_pc1, upd_pc2;
    logic [3:0]  queue_count;
    logic        overflow_err;

    int total = 0;
    int bad   = 0;

    // reference model state
    bp_upd_t     mq[$];
    logic        e_v1, e_v2, e_r1, e_r2, e_ovf;
    logic [63:0] e_pc1, e_pc2;

    bp_update_sched #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset_n(reset_n), .pred_enable(pred_enable), .upd_hold(upd_hold),
        .cmp_valid1(cmp_valid1), .cmp_pc1(cmp_pc1), .cmp_taken1(cmp_taken1),
        .cmp_valid2(cmp_valid2), .cmp_pc2(cmp_pc2), .cmp_taken2(cmp_taken2),
        .cmp_ready(cmp_ready),
        .upd_valid1(upd_valid1), .upd_pc1(upd_pc1), .upd_result1(upd_result1),
        .upd_valid2(upd_valid2), .upd_pc2(upd_pc2), .upd_result2(upd_result2),
        .queue_count(queue_count), .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit same_idx(input logic [63:0] a, input logic [63:0] b);
        return a[IDX_W+1:2] == b[IDX_W+1:2];
    endfunction

    // Behavioural model: what one rising edge does, given inputs and queue before it.
    task automatic model_edge();
        int sz;
        bit rdy, serialize;
        bp_upd_t h0, h1;
        e_v1 = 0; e_v2 = 0; e_r1 = 0; e_r2 = 0; e_pc1 = 0; e_pc2 = 0;
        if (!reset_n) begin
            mq.delete();
            e_ovf = 0;
            return;
        end
        if (!pred_enable) begin
            mq.delete();
            return;
        end
        sz  = mq.size();
        rdy = (DEPTH - sz) >= 2;
`ifdef BP_SAME_INDEX_SERIALIZE_EN
        serialize = 1;
`else
        serialize = 0;
`endif
        if (!upd_hold && sz > 0) begin
            h0 = mq.pop_front();
            e_v1 = 1; e_pc1 = h0.pc; e_r1 = h0.taken;
            if (sz >= 2) begin
                h1 = mq[0];
                if (!(serialize && same_idx(h0.pc, h1.pc))) begin
                    void'(mq.pop_front());
                    e_v2 = 1; e_pc2 = h1.pc; e_r2 = h1.taken;
                end
            end
        end
        if (rdy) begin
            if (cmp_valid1) mq.push_back('{pc: cmp_pc1, taken: cmp_taken1});
            if (cmp_valid2) mq.push_back('{pc: cmp_pc2, taken: cmp_taken2});
        end else if (cmp_valid1 || cmp_valid2) begin
            e_ovf = 1;
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ".count"}, 64'(queue_count), 64'(mq.size()));
        check({ph, ".ready"}, 64'(cmp_ready), 64'((DEPTH - mq.size()) >= 2));
        check({ph, ".ovf"},   64'(overflow_err), 64'(e_ovf));
        check({ph, ".v1"},    64'(upd_valid1), 64'(e_v1));
        check({ph, ".v2"},    64'(upd_valid2), 64'(e_v2));
        if (e_v1) begin
            check({ph, ".pc1"}, upd_pc1, e_pc1);
            check({ph, ".r1"},  64'(upd_result1), 64'(e_r1));
        end
        if (e_v2) begin
            check({ph, ".pc2"}, upd_pc2, e_pc2);
            check({ph, ".r2"},  64'(upd_result2), 64'(e_r2));
        end
    endtask

    task automatic tick(input string ph);
        @(posedge clock);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic drive(input logic v1, input logic [63:0] p1, input logic t1,
                         input logic v2, input logic [63:0] p2, input logic t2);
        cmp_valid1 = v1; cmp_pc1 = p1; cmp_taken1 = t1;
        cmp_valid2 = v2; cmp_pc2 = p2; cmp_taken2 = t2;
    endtask

    function automatic logic [63:0] rand_pc();
        case ($urandom_range(0, 4))
            0: return 64'h100;
            1: return 64'h140;
            2: return 64'h104;
            3: return 64'h208;
            default: return 64'h1000 + 64'($urandom_range(0, 255)) * 4;
        endcase
    endfunction

    initial begin
        reset_n = 0; pred_enable = 1; upd_hold = 0;
        drive(0, 0, 0, 0, 0, 0);
        e_ovf = 0;
        tick("rst"); tick("rst");
        check("rst.pc1", upd_pc1, 64'd0);
        check("rst.pc2", upd_pc2, 64'd0);
        check("rst.res", 64'({upd_result1, upd_result2}), 64'd0);
        reset_n = 1;

        // single branch, 2-edge latency
        drive(1, 64'h100, 1, 0, 0, 0);
        tick("single.wr");
        drive(0, 0, 0, 0, 0, 0);
        tick("single.iss");
        check("single.pc1_direct", upd_pc1, 64'h100);
        tick("single.idle");

        // fill under hold, overflow, then paired drain
        upd_hold = 1;
        drive(1, 64'h100, 0, 1, 64'h104, 1);
        for (int i = 0; i < 5; i++) tick("fill");
        check("fill.count8", 64'(queue_count), 64'd8);
        check("fill.ovf1", 64'(overflow_err), 64'd1);
        drive(0, 0, 0, 0, 0, 0);
        upd_hold = 0;
        for (int i = 0; i < 5; i++) tick("drain");

        // same-index pair
        drive(1, 64'h100, 1, 1, 64'h140, 0);
        tick("same.wr");
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("same.iss");

        // slot 2 alone
        drive(0, 0, 0, 1, 64'h208, 1);
        tick("s2.wr");
        drive(0, 0, 0, 0, 0, 0);
        tick("s2.iss");
        tick("s2.idle");

        // clear overflow, queue 5, then disable with inputs present
        reset_n = 0; tick("rst2"); reset_n = 1;
        upd_hold = 1;
        drive(1, 64'h300, 1, 1, 64'h304, 0); tick("q5");
        tick("q5");
        drive(1, 64'h308, 1, 0, 0, 0); tick("q5");
        check("q5.count", 64'(queue_count), 64'd5);
        upd_hold = 0; pred_enable = 0;
        drive(1, 64'h400, 1, 1, 64'h404, 1);
        tick("dis"); tick("dis");
        check("dis.ovf0", 64'(overflow_err), 64'd0);
        pred_enable = 1;
        drive(0, 0, 0, 0, 0, 0);
        tick("dis.after");

        // reset with 4 queued
        upd_hold = 1;
        drive(1, 64'h500, 1, 1, 64'h504, 1); tick("q4"); tick("q4");
        drive(0, 0, 0, 0, 0, 0);
        reset_n = 0; upd_hold = 0;
        tick("rst3");
        reset_n = 1;
        tick("rst3.after"); tick("rst3.after");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset_n     = ($urandom_range(0, 99) != 0);
            pred_enable = ($urandom_range(0, 19) != 0);
            upd_hold    = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 1) == 1, rand_pc(), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, rand_pc(), $urandom_range(0, 1) == 1);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
